// File: rtl/spi_adc_rx_multi.sv
// Multi-channel AD7276-style serial ADC receiver: drives shared CS_n/SCLK,
// captures NUM_CH parallel MISO lines and presents all channels as one AXIS beat.
module spi_adc_rx_multi #(
    parameter int NUM_CH         = 2,
    parameter int ADC_BITS       = 12,
    parameter int FRAME_BITS     = 14,
    parameter int LEAD_ZEROS     = 2,
    parameter int QUIET_CYC      = 4,
    parameter int DEF_SAMPLE_DIV = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            sample_div,
    input  logic [7:0]             sclk_half_div,
    input  logic                   clear_status,
    input  logic [NUM_CH-1:0]      miso,
    output logic                   cs_n,
    output logic                   sclk,
    output logic [16*NUM_CH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   overrun,
    output logic                   trig_miss,
    output logic                   busy
);

    localparam int HP_LAST = 2*FRAME_BITS - 1;
    localparam int HPW     = $clog2(2*FRAME_BITS);
    localparam int QUIET_N = (QUIET_CYC < 1) ? 1 : QUIET_CYC;
    localparam int QW      = $clog2(QUIET_N + 1);
    localparam int MSB_POS = FRAME_BITS - 1 - LEAD_ZEROS;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    state_t                state;
    logic [31:0]           eff_div;
    logic [31:0]           p_cur;
    logic [31:0]           smp_cnt;
    logic                  tick;
    logic [7:0]            h_eff;
    logic [7:0]            hcnt;
    logic                  h_evt;
    logic [HPW-1:0]        hp_cnt;
    logic [QW-1:0]         qcnt;
    logic [FRAME_BITS-1:0] shreg [NUM_CH];

    assign eff_div = (sample_div == '0) ? 32'(DEF_SAMPLE_DIV) : sample_div;
    assign h_eff   = (sclk_half_div == '0) ? 8'd1 : sclk_half_div;
    assign h_evt   = (hcnt == h_eff - 8'd1);
    assign tick    = enable && (smp_cnt == p_cur - 32'd1);
    assign busy    = (state != IDLE);

    // The period is latched only at wrap (or while disabled) so a new
    // sample_div never truncates or stretches the period in progress.
    always_ff @(posedge clk) begin
        if (!rst || !enable || tick) begin
            smp_cnt <= '0;
            p_cur   <= eff_div;
        end else begin
            smp_cnt <= smp_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cs_n          <= 1'b1;
            sclk          <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            overrun       <= 1'b0;
            trig_miss     <= 1'b0;
            hcnt          <= '0;
            hp_cnt        <= '0;
            qcnt          <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                shreg[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b1;
                    hcnt <= '0;
                    if (tick) begin
                        state <= SETUP;
                        cs_n  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (h_evt) begin
                        hcnt   <= '0;
                        hp_cnt <= '0;
                        sclk   <= 1'b0;
                        state  <= SHIFT;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (h_evt) begin
                        hcnt <= '0;
                        if (hp_cnt == HPW'(HP_LAST)) begin
                            state <= DONE;
                            cs_n  <= 1'b1;
                            sclk  <= 1'b1;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                            sclk   <= ~sclk;
                            // Capture on the edge that raises sclk.
                            if (!sclk) begin
                                for (int unsigned k = 0; k < NUM_CH; k++) begin
                                    shreg[k] <= {shreg[k][FRAME_BITS-2:0], miso[k]};
                                end
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                DONE: begin
                    qcnt  <= '0;
                    state <= QUIET;
                end
                QUIET: begin
                    if (qcnt == QW'(QUIET_N - 1)) begin
                        state <= IDLE;
                    end else begin
                        qcnt <= qcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == DONE && (!m_axis_tvalid || m_axis_tready)) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    m_axis_tdata[16*k +: 16] <= 16'(shreg[k][MSB_POS -: ADC_BITS]);
                end
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (state == DONE && m_axis_tvalid && !m_axis_tready) begin
                overrun <= 1'b1;
            end else if (clear_status) begin
                overrun <= 1'b0;
            end

            if (tick && state != IDLE) begin
                trig_miss <= 1'b1;
            end else if (clear_status) begin
                trig_miss <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_rx_multi.sv
// Directed bench for spi_adc_rx_multi with a behavioural two-channel ADC model
// that presents the MSB on CS_n fall and advances on each later SCLK fall.
module tb_spi_adc_rx_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] sample_div;
    logic [7:0]  sclk_half_div;
    logic        clear_status;
    logic [1:0]  miso = 2'b00;
    logic        cs_n;
    logic        sclk;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overrun;
    logic        trig_miss;
    logic        busy;

    spi_adc_rx_multi #(
        .NUM_CH(2),
        .ADC_BITS(12),
        .FRAME_BITS(14),
        .LEAD_ZEROS(2),
        .QUIET_CYC(4),
        .DEF_SAMPLE_DIV(48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sample_div(sample_div),
        .sclk_half_div(sclk_half_div),
        .clear_status(clear_status),
        .miso(miso),
        .cs_n(cs_n),
        .sclk(sclk),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .overrun(overrun),
        .trig_miss(trig_miss),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ADC model: 14-bit frame words per channel (lead bits included).
    logic [13:0] word [2];
    int bidx  = 0;
    int nfall = 0;

    always @(negedge cs_n) begin
        bidx  = 0;
        nfall = 0;
        miso  = {word[1][13], word[0][13]};
    end

    always @(negedge sclk) begin
        if (cs_n === 1'b0) begin
            if (nfall > 0 && bidx < 13) bidx++;
            nfall++;
            miso = {word[1][13-bidx], word[0][13-bidx]};
        end
    end

    // Pin monitor.
    int cyc = 0;
    int cs_fall_cyc = 0;
    int rises = 0;
    int low_run = 0;
    int max_low = 0;
    int tv_q[$];
    int csf_q[$];
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b1;
    logic prev_tv = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_cs === 1'b1 && cs_n === 1'b0) begin
            cs_fall_cyc = cyc;
            rises       = 0;
            low_run     = 0;
            csf_q.push_back(cyc);
        end
        if (cs_n === 1'b0) begin
            low_run++;
            if (low_run > max_low) max_low = low_run;
            if (sclk === 1'b1 && prev_sclk === 1'b0) rises++;
        end
        if (m_axis_tvalid === 1'b1 && prev_tv !== 1'b1) tv_q.push_back(cyc);
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_tv   = m_axis_tvalid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tvalid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  hdiv;
        logic [31:0] sdiv;
        logic [13:0] w0;
        logic [13:0] w1;
        logic [31:0] exp_data;
        int          exp_lat;   // cycles from cs_n low to tvalid high = H + 28H + 1
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit ok;
        int base;

        vecs[0] = '{8'd1, 32'd48,  14'h0A5C, 14'h03F1, 32'h03F1_0A5C, 30};
        vecs[1] = '{8'd0, 32'd0,   14'h0FFF, 14'h3000, 32'h0000_0FFF, 30};
        vecs[2] = '{8'd0, 32'd0,   14'h3000, 14'h3FFF, 32'h0FFF_0000, 30};
        vecs[3] = '{8'd2, 32'd100, 14'h0123, 14'h0ABC, 32'h0ABC_0123, 59};
        vecs[4] = '{8'd3, 32'd200, 14'h0800, 14'h0001, 32'h0001_0800, 88};

        rst           = 1'b0;
        enable        = 1'b0;
        sample_div    = 32'd48;
        sclk_half_div = 8'd1;
        clear_status  = 1'b0;
        m_axis_tready = 1'b1;
        word[0]       = 14'h0;
        word[1]       = 14'h0;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {cs_n, sclk, m_axis_tvalid, overrun, trig_miss, busy}, 6'b110000);
        check("reset_tdata", m_axis_tdata, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames.
        for (int i = 0; i < 5; i++) begin
            enable        = 1'b0;
            sclk_half_div = vecs[i].hdiv;
            sample_div    = vecs[i].sdiv;
            word[0]       = vecs[i].w0;
            word[1]       = vecs[i].w1;
            repeat (3) @(negedge clk);
            enable = 1'b1;
            wait_tvalid(600, ok);
            check($sformatf("vec%0d_tvalid_seen", i), ok, 1'b1);
            check($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), cyc - cs_fall_cyc, vecs[i].exp_lat);
            check($sformatf("vec%0d_sclk_rises", i), rises, 14);
            enable = 1'b0;
            wait_idle(400, ok);
        end

        // Sample period: default then explicit 100.
        sclk_half_div = 8'd1;
        sample_div    = 32'd0;
        word[0]       = 14'h0155;
        word[1]       = 14'h02AA;
        repeat (3) @(negedge clk);
        tv_q.delete();
        enable = 1'b1;
        for (int n = 0; n < 1000 && tv_q.size() < 10; n++) @(negedge clk);
        check("period48_count", tv_q.size() >= 10, 1'b1);
        if (tv_q.size() >= 10)
            for (int i = 0; i < 9; i++)
                check($sformatf("period48_gap%0d", i), tv_q[i+1] - tv_q[i], 48);
        enable = 1'b0;
        wait_idle(200, ok);
        sample_div = 32'd100;
        repeat (3) @(negedge clk);
        tv_q.delete();
        enable = 1'b1;
        for (int n = 0; n < 1000 && tv_q.size() < 4; n++) @(negedge clk);
        check("period100_count", tv_q.size() >= 4, 1'b1);
        if (tv_q.size() >= 4)
            for (int i = 0; i < 3; i++)
                check($sformatf("period100_gap%0d", i), tv_q[i+1] - tv_q[i], 100);
        enable = 1'b0;
        wait_idle(200, ok);

        // Backpressure across two frames.
        sample_div    = 32'd48;
        m_axis_tready = 1'b0;
        word[0]       = 14'h0111;
        word[1]       = 14'h0222;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_tvalid(200, ok);
        check("bp_first_seen", ok, 1'b1);
        check("bp_first_tdata", m_axis_tdata, 32'h0222_0111);
        word[0] = 14'h0333;
        word[1] = 14'h0444;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (overrun === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_overrun_set", ok, 1'b1);
        check("bp_tvalid_held", m_axis_tvalid, 1'b1);
        check("bp_tdata_held", m_axis_tdata, 32'h0222_0111);
        enable = 1'b0;
        wait_idle(200, ok);
        check("bp_tdata_before_accept", m_axis_tdata, 32'h0222_0111);
        check("bp_trig_miss_clear", trig_miss, 1'b0);
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("bp_tvalid_after_accept", m_axis_tvalid, 1'b0);
        check("bp_overrun_sticky", overrun, 1'b1);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        check("bp_overrun_cleared", overrun, 1'b0);

        // Missed trigger: frame longer than the sample period.
        sclk_half_div = 8'd4;
        sample_div    = 32'd20;
        word[0]       = 14'h05A5;
        word[1]       = 14'h01E1;
        repeat (3) @(negedge clk);
        csf_q.delete();
        max_low = 0;
        enable  = 1'b1;
        repeat (700) @(negedge clk);
        enable = 1'b0;
        wait_idle(300, ok);
        repeat (2) @(negedge clk);
        check("miss_trig_miss", trig_miss, 1'b1);
        check("miss_cs_low_max", max_low, 116);
        check("miss_frame_count", csf_q.size() >= 3, 1'b1);
        if (csf_q.size() >= 3)
            for (int i = 0; i < 2; i++)
                check($sformatf("miss_spacing%0d", i), csf_q[i+1] - csf_q[i], 140);
        check("miss_tdata", m_axis_tdata, 32'h01E1_05A5);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        check("miss_cleared", trig_miss, 1'b0);

        // Reset asserted in the middle of SHIFT.
        sclk_half_div = 8'd1;
        sample_div    = 32'd48;
        word[0]       = 14'h0777;
        word[1]       = 14'h0888;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cs_n === 1'b0 && rises == 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_reached_bit5", ok, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ctrl", {cs_n, sclk, m_axis_tvalid, busy}, 4'b1100);
        check("rstmid_tdata", m_axis_tdata, 32'h0);
        rst     = 1'b1;
        word[0] = 14'h0C3A;
        word[1] = 14'h0246;
        wait_tvalid(300, ok);
        check("rstmid_after_seen", ok, 1'b1);
        check("rstmid_after_tdata", m_axis_tdata, 32'h0246_0C3A);
        base = cyc - cs_fall_cyc;
        check("rstmid_after_latency", base, 30);
        enable = 1'b0;
        wait_idle(200, ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_adc_rx_multi.md
Name: spi_adc_rx_multi

Overview:
- Parametrised successor to the dual-channel AD7276-style serial ADC receiver.
- Generates CS_n/SCLK for NUM_CH parallel-MISO ADCs sharing one chip select and clock, with a programmable SCLK divider and sample-rate divider.
- Extracts ADC_BITS from each FRAME_BITS frame and presents all channels as one beat on an AXI4-Stream master with valid/ready backpressure.
- Reports overrun and missed-trigger status; sits between the ADC pins and the downstream AXIS capture/DMA path.

Parameters:
- NUM_CH, 2, number of ADC channels (MISO lines), 1..8.
- ADC_BITS, 12, conversion result width, ≤16.
- FRAME_BITS, 14, SCLK cycles per conversion; must be ≥ LEAD_ZEROS+ADC_BITS.
- LEAD_ZEROS, 2, leading bits discarded before MSB.
- QUIET_CYC, 4, minimum clk cycles CS_n stays high after a frame before the next frame may start.
- DEF_SAMPLE_DIV, 48, sample period used when sample_div==0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- enable  in  1  conversion enable
- sample_div  in  32  sample period in clk cycles (0 → DEF_SAMPLE_DIV)
- sclk_half_div  in  8  SCLK half-period in clk cycles (0 treated as 1)
- clear_status  in  1  clears sticky status bits
- miso  in  NUM_CH  serial data, one per ADC
- cs_n  out  1  chip select, active-low
- sclk  out  1  serial clock, idles high
- m_axis_tdata  out  16*NUM_CH  channel k in bits [16k+15:16k], right-justified, zero-extended
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready
- overrun  out  1  sticky: frame completed while the previous beat was still unaccepted
- trig_miss  out  1  sticky: sample tick arrived while not IDLE
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset is synchronous, active-low, clock clk. While rst=0:
  - cs_n=1, sclk=1, tvalid=0, tdata=0, overrun=0, trig_miss=0, busy=0.
  - State = IDLE; sample and half-period counters cleared.
- Sample timer:
  - Counts every clk while enable=1; otherwise held at 0.
  - tick asserts for one cycle when count == P-1 (P = effective sample_div), then the count wraps to 0. Tick period is exactly P cycles.
  - sample_div changes take effect at the next wrap.
- Half-period timer, H = max(sclk_half_div,1): advances only in SETUP and SHIFT; an event fires every H cycles.
- FSM (registered state):
  - IDLE: cs_n=1, sclk=1. On tick with enable=1 → SETUP, with cs_n=0 on the next cycle.
  - SETUP: cs_n=0, sclk=1 for H cycles → SHIFT.
  - SHIFT: 2*FRAME_BITS half-periods; sclk goes low, then high, alternately.
    - On each clk edge that drives sclk low→high, shift miso[k] into shreg[k] (MSB first).
    - After the FRAME_BITS-th rising edge → DONE.
  - DONE (1 cycle): cs_n=1, sclk=1. Result for channel k = shreg[k][FRAME_BITS-1-LEAD_ZEROS -: ADC_BITS].
    - If tvalid=0, or tvalid&&tready this cycle: load tdata and set tvalid=1 on the next cycle.
    - Otherwise: discard the new result, keep tdata stable, set overrun.
    - Then → QUIET.
  - QUIET: cs_n=1 for QUIET_CYC cycles → IDLE.
- Frame length from tick to tvalid rise: 1 + H + 2*FRAME_BITS*H + 1 cycles.
- Status:
  - trig_miss sets on any tick while state ≠ IDLE; that tick is ignored and does not queue.
  - overrun and trig_miss clear on clear_status=1; a set event in the same cycle wins.
- AXIS:
  - tvalid falls on the cycle after tvalid&&tready unless a new load occurs the same cycle.
  - tdata is held constant while tvalid&&!tready.
- enable falling mid-frame: the current frame completes and outputs normally; no new frames start.
- rst=0 mid-frame: immediate abort to the reset values above; the partial frame is lost.
- Unused upper lane bits [16k+15:16k+ADC_BITS] are always 0.

Test Plan:
- Basic, NUM_CH=2, H=1, sample_div=48, ADC model returns 0xA5C on ch0 and 0x3F1 on ch1 with 2 leading zeros, tready=1 → tdata=32'h03F1_0A5C; tvalid rises 31 cycles after tick; exactly 14 sclk rising edges per frame while cs_n=0.
- Period, sample_div=0, 10 frames → tvalid pulses exactly 48 cycles apart; sample_div=100 → 100 cycles apart.
- Backpressure, tready=0 across two frames → first beat held unchanged, overrun=1; tready=1 → first data accepted; clear_status → overrun=0.
- Missed trigger, H=4, sample_div=20 (frame 118 cycles + quiet) → trig_miss=1, cs_n never low for more than 1+4+112 cycles, frames spaced at multiples of 20.
- Reset mid-SHIFT, rst=0 at bit 5 → next cycle cs_n=1, sclk=1, tvalid=0; after release the first frame is decoded correctly.
- Edge data, 0xFFF and 0x000, sclk_half_div=0 → behaves as H=1; lanes equal 0x0FFF and 0x0000; the discarded lead-zero bits do not leak into the result.
